// File: rtl/param_fifo_buffer.sv
// rtl/param_fifo_buffer.sv - parametrised synchronous FIFO for router channel buffering
//
// Purpose:
//   Circular-buffer FIFO with registered read data (one-cycle read latency),
//   occupancy count and almost-full/almost-empty thresholds. Handles
//   simultaneous read/write at both full and empty, and any DEPTH (not only
//   powers of two).
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   wr_en        in   write request
//   data_in      in   write data [DATA_WIDTH]
//   rd_en        in   read request
//   data_out     out  registered read data [DATA_WIDTH]
//   rd_valid     out  one-cycle pulse when data_out was updated by a read
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  current occupancy [CNT_W]
//   overflow     out  sticky dropped-write flag (FIFO_ERR_FLAGS_EN only)
//   underflow    out  sticky empty-read flag (FIFO_ERR_FLAGS_EN only)
//
// Build option: define FIFO_ERR_FLAGS_EN to add the overflow/underflow ports.

module param_fifo_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;

  logic full_w, empty_w, wr_acc, rd_acc;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags come only from the registered count.
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // A read frees a slot in the same edge, so a write at full is allowed
  // alongside it; a write at empty is never forwarded to the read side.
  assign rd_acc = rd_en & ~empty_w;
  assign wr_acc = wr_en & (~full_w | rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;

    if (rd_acc) begin
      data_out_d = mem[rd_ptr_q];
      rd_ptr_d   = next_ptr(rd_ptr_q);
      rd_valid_d = 1'b1;
    end

    if (wr_acc) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is not reset; requests during reset must not land in it.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A write at full with a read present is legal, so only a lone write overflows.
  always_comb begin
    overflow_d  = overflow_q | (wr_en & full_w & ~rd_en);
    underflow_d = underflow_q | (rd_en & empty_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_param_fifo_buffer.sv
// tb/tb_param_fifo_buffer.sv - self-checking bench for param_fifo_buffer

module tb_param_fifo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: DEPTH=4, default thresholds (AF=3, AE=1)
  logic       a_rst, a_wr, a_rd;
  logic [7:0] a_din, a_dout;
  logic       a_rv, a_full, a_empty, a_af, a_ae;
  logic [2:0] a_cnt;
`ifdef FIFO_ERR_FLAGS_EN
  logic       a_ovf, a_unf;
`endif

  param_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
    .data_out(a_dout), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(a_ovf), .underflow(a_unf)
`endif
  );

  // Instance B: DEPTH=5 (non-power-of-two), AF=3, AE=2
  localparam int B_DEPTH = 5;
  localparam int B_AF    = 3;
  localparam int B_AE    = 2;
  logic       b_rst, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_rv, b_full, b_empty, b_af, b_ae;
  logic [2:0] b_cnt;
`ifdef FIFO_ERR_FLAGS_EN
  logic       b_ovf, b_unf;
`endif

  param_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(B_DEPTH), .AF_THRESH(B_AF), .AE_THRESH(B_AE)) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
    .data_out(b_dout), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(b_ovf), .underflow(b_unf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, wr, rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rv;
    int         cnt;
    logic       full, empty, af, ae;
  } vec_t;

  function automatic vec_t mk(logic rst, logic wr, logic rd, logic [7:0] din, logic [7:0] dout,
                              logic rv, int cnt, logic full, logic empty, logic af, logic ae);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.rv = rv;
    v.cnt = cnt; v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    return v;
  endfunction

  task automatic step_a(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
    a_rst = rst; a_wr = wr; a_rd = rd; a_din = din;
    @(posedge clk);
    #1;
  endtask

  // Reference model for B: a plain word queue plus the output register.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_rv;

  task automatic step_b(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
    bit ra, wa;
    b_rst = rst; b_wr = wr; b_rd = rd; b_din = din;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_rv   = 1'b0;
    end else begin
      ra = rd && (mq.size() > 0);
      wa = wr && ((mq.size() < B_DEPTH) || ra);
      if (ra) begin
        m_dout = mq.pop_front();
        m_rv   = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (wa) mq.push_back(din);
    end
    chk("b_dout",  b_dout,  m_dout);
    chk("b_rv",    b_rv,    m_rv);
    chk("b_count", b_cnt,   mq.size());
    chk("b_full",  b_full,  mq.size() == B_DEPTH);
    chk("b_empty", b_empty, mq.size() == 0);
    chk("b_af",    b_af,    mq.size() >= B_AF);
    chk("b_ae",    b_ae,    mq.size() <= B_AE);
  endtask

  initial begin
    vec_t vecs[$];
    a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;

    //           rst wr rd din    dout  rv cnt full empty af ae
    vecs.push_back(mk(1, 1, 1, 8'hEE, 8'h00, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h22, 8'h00, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h33, 8'h00, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h44, 8'h00, 0, 4, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h11, 1, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h22, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h33, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h44, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h44, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h44, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hA0, 8'h44, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hA1, 8'h44, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hA2, 8'h44, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'hA3, 8'h44, 0, 4, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'hC0, 8'h44, 0, 4, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'hB0, 8'hA0, 1, 4, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hA1, 1, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hA2, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hA3, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hB0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h55, 8'hB0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h55, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h01, 8'h55, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h02, 8'h55, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h03, 8'h55, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h07, 8'h00, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h07, 1, 0, 0, 1, 0, 1));

    foreach (vecs[i]) begin
      step_a(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("v%0d_dout", i),  a_dout,  vecs[i].dout);
      chk($sformatf("v%0d_rv", i),    a_rv,    vecs[i].rv);
      chk($sformatf("v%0d_count", i), a_cnt,   vecs[i].cnt);
      chk($sformatf("v%0d_full", i),  a_full,  vecs[i].full);
      chk($sformatf("v%0d_empty", i), a_empty, vecs[i].empty);
      chk($sformatf("v%0d_af", i),    a_af,    vecs[i].af);
      chk($sformatf("v%0d_ae", i),    a_ae,    vecs[i].ae);
    end

    // Sustained simultaneous read/write while full: stays full, strict order.
    step_a(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step_a(0, 1, 0, 8'(i + 1));
    for (int i = 0; i < 6; i++) begin
      step_a(0, 1, 1, 8'(i + 5));
      chk($sformatf("fullrw%0d_dout", i), a_dout, 8'(i + 1));
      chk($sformatf("fullrw%0d_rv", i),   a_rv,   1'b1);
      chk($sformatf("fullrw%0d_count", i), a_cnt, 3'd4);
      chk($sformatf("fullrw%0d_full", i), a_full, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      step_a(0, 0, 1, 8'h00);
      chk($sformatf("drain%0d_dout", i),  a_dout, 8'(i + 7));
      chk($sformatf("drain%0d_count", i), a_cnt,  3'(3 - i));
    end
    step_a(0, 0, 0, 8'h00);

`ifdef FIFO_ERR_FLAGS_EN
    step_a(1, 0, 0, 8'h00);
    chk("err_rst_ovf", a_ovf, 1'b0);
    chk("err_rst_unf", a_unf, 1'b0);
    step_a(0, 0, 1, 8'h00);
    chk("unf_set", a_unf, 1'b1);
    chk("unf_no_ovf", a_ovf, 1'b0);
    step_a(0, 0, 0, 8'h00);
    chk("unf_sticky", a_unf, 1'b1);
    for (int i = 0; i < 4; i++) step_a(0, 1, 0, 8'(8'h60 + i));
    chk("fill_no_ovf", a_ovf, 1'b0);
    step_a(0, 1, 1, 8'h70);
    chk("fullrw_no_ovf", a_ovf, 1'b0);
    step_a(0, 1, 0, 8'h71);
    chk("ovf_set", a_ovf, 1'b1);
    chk("ovf_count", a_cnt, 3'd4);
    step_a(0, 0, 0, 8'h00);
    chk("ovf_sticky", a_ovf, 1'b1);
    step_a(1, 0, 0, 8'h00);
    chk("ovf_clr", a_ovf, 1'b0);
    chk("unf_clr", a_unf, 1'b0);
    step_a(0, 0, 0, 8'h00);
`endif

    // B: streaming with wrap on a non-power-of-two depth, then random traffic.
    step_b(1, 0, 0, 8'h00);
    for (int i = 0; i < 24; i++) begin
      step_b(0, (mq.size() < B_DEPTH), (mq.size() >= 2) && (i % 3 != 0), 8'(8'h80 + i));
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      int wp;
      wp = ((cyc / 100) % 2 == 0) ? 70 : 30;
      step_b($urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < (100 - wp),
             8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
